// File: rtl/nec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nec_pkg
//  Description : Shared types and timing windows for the NEC IR decoder.
//                All window limits are in microseconds, inclusive.
//  Revision    : 1.0 - initial release
// ============================================================================
package nec_pkg;

    localparam int DUR_W = 14;

    typedef logic [DUR_W-1:0] dur_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LEAD_LOW  = 3'd1,
        LEAD_HIGH = 3'd2,
        BIT_LOW   = 3'd3,
        BIT_HIGH  = 3'd4,
        STOP_LOW  = 3'd5,
        RPT_LOW   = 3'd6
    } nec_state_t;

    localparam dur_t c_lead_lo_min      = 14'd8000;
    localparam dur_t c_lead_lo_max      = 14'd10000;
    localparam dur_t c_lead_hi_data_min = 14'd4000;
    localparam dur_t c_lead_hi_data_max = 14'd5000;
    localparam dur_t c_lead_hi_rpt_min  = 14'd2000;
    localparam dur_t c_lead_hi_rpt_max  = 14'd2500;
    localparam dur_t c_bit_min          = 14'd400;
    localparam dur_t c_bit_max          = 14'd700;
    localparam dur_t c_one_hi_min       = 14'd1400;
    localparam dur_t c_one_hi_max       = 14'd1900;

    // Inclusive range test used by every window decision
    function automatic logic in_window(input dur_t dur, input dur_t lo, input dur_t hi);
        return (dur >= lo) && (dur <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nec_us_timer.sv
`default_nettype none
// ============================================================================
//  Module      : nec_us_timer
//  Description : Microsecond duration counter. A prescaler divides sys_clk
//                by US_DIV; the microsecond count saturates at all-ones.
//                Both restart from zero whenever clear is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module nec_us_timer
    import nec_pkg::*;
#(
    parameter int US_DIV = 27
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             clear,
    output logic [DUR_W-1:0] dur
);

    localparam int                 c_pre_w    = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(US_DIV - 1);

    logic [c_pre_w-1:0] r_presc;
    dur_t               r_us;

    // Prescaler and saturating microsecond counter, restarted on clear
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_presc <= '0;
            r_us    <= '0;
        end else if (clear) begin
            r_presc <= '0;
            r_us    <= '0;
        end else if (r_presc == c_pre_last) begin
            r_presc <= '0;
            if (r_us != '1) begin
                r_us <= r_us + 1'b1;
            end
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign dur = r_us;

endmodule
`default_nettype wire

// File: rtl/nec_ir_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : nec_ir_decoder
//  Description : NEC infrared frame decoder. Measures pulse widths of the
//                synchronized IR level, walks leader / 32 data bits / stop,
//                and presents address, command and repeat codes on a
//                valid/ready interface.
//                Build option: define NEC_EXT_ADDR_EN for extended NEC
//                (16-bit address, no address inverse check).
//  Revision    : 1.0 - initial release
// ============================================================================
module nec_ir_decoder
    import nec_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 27_000_000,
    parameter int TIMEOUT_US  = 12000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        ir_level,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_addr,
    output logic [7:0]  out_cmd,
    output logic        out_repeat,
    output logic        err_pulse,
    output logic        overrun_pulse
);

    localparam int   US_DIV    = CLK_FREQ_HZ / 1_000_000;
    localparam dur_t c_timeout = DUR_W'(TIMEOUT_US);

    logic        r_ir_prev;
    logic        w_fall;
    logic        w_rise;
    logic        w_edge;
    dur_t        w_dur;

    nec_state_t  r_state;
    nec_state_t  w_state_next;

    logic [31:0] r_shift;
    logic [4:0]  r_bit_cnt;
    logic        r_have_frame;
    logic [15:0] r_last_addr;
    logic [7:0]  r_last_cmd;

    logic        w_shift_en;
    logic        w_shift_bit;
    logic        w_bit_clr;
    logic        w_publish;
    logic        w_pub_rpt;
    logic        w_err;

    logic [7:0]  w_byte0;
    logic [7:0]  w_byte1;
    logic [7:0]  w_byte2;
    logic [7:0]  w_byte3;
    logic        w_frame_ok;
    logic [15:0] w_frame_addr;
    logic [15:0] w_pub_addr;
    logic [7:0]  w_pub_cmd;

    assign w_fall = r_ir_prev & ~ir_level;
    assign w_rise = ~r_ir_prev & ir_level;
    assign w_edge = w_fall | w_rise;

    // Previous IR level for edge detection; idle line is high
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_ir_prev <= 1'b1;
        end else begin
            r_ir_prev <= ir_level;
        end
    end

    // Every edge restarts the measurement; w_dur is the width just ended
    nec_us_timer #(
        .US_DIV (US_DIV)
    ) u_us_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clear     (w_edge),
        .dur       (w_dur)
    );

    // Byte 0 is transmitted first and ends up in the low byte after 32 shifts
    assign w_byte0 = r_shift[7:0];
    assign w_byte1 = r_shift[15:8];
    assign w_byte2 = r_shift[23:16];
    assign w_byte3 = r_shift[31:24];

`ifdef NEC_EXT_ADDR_EN
    assign w_frame_ok   = ((w_byte2 ^ w_byte3) == 8'hFF);
    assign w_frame_addr = {w_byte1, w_byte0};
`else
    assign w_frame_ok   = ((w_byte2 ^ w_byte3) == 8'hFF) &&
                          ((w_byte0 ^ w_byte1) == 8'hFF);
    assign w_frame_addr = {8'h00, w_byte0};
`endif

    assign w_pub_addr = w_pub_rpt ? r_last_addr : w_frame_addr;
    assign w_pub_cmd  = w_pub_rpt ? r_last_cmd  : w_byte2;

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-cycle strobes for the datapath
    always_comb begin
        w_state_next = r_state;
        w_shift_en   = 1'b0;
        w_shift_bit  = 1'b0;
        w_bit_clr    = 1'b0;
        w_publish    = 1'b0;
        w_pub_rpt    = 1'b0;
        w_err        = 1'b0;

        // An edge always restarts timing, so timeout only applies between edges
        if ((r_state != IDLE) && !w_edge && (w_dur >= c_timeout)) begin
            w_err        = 1'b1;
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        w_state_next = LEAD_LOW;
                    end
                end
                LEAD_LOW: begin
                    if (w_rise) begin
                        if (in_window(w_dur, c_lead_lo_min, c_lead_lo_max)) begin
                            w_state_next = LEAD_HIGH;
                        end else begin
                            w_err        = 1'b1;
                            w_state_next = IDLE;
                        end
                    end
                end
                LEAD_HIGH: begin
                    if (w_fall) begin
                        if (in_window(w_dur, c_lead_hi_data_min, c_lead_hi_data_max)) begin
                            w_bit_clr    = 1'b1;
                            w_state_next = BIT_LOW;
                        end else if (in_window(w_dur, c_lead_hi_rpt_min, c_lead_hi_rpt_max)) begin
                            w_state_next = RPT_LOW;
                        end else begin
                            // The offending fall may itself start a new leader
                            w_err        = 1'b1;
                            w_state_next = LEAD_LOW;
                        end
                    end
                end
                BIT_LOW: begin
                    if (w_rise) begin
                        if (in_window(w_dur, c_bit_min, c_bit_max)) begin
                            w_state_next = BIT_HIGH;
                        end else begin
                            w_err        = 1'b1;
                            w_state_next = IDLE;
                        end
                    end
                end
                BIT_HIGH: begin
                    if (w_fall) begin
                        if (in_window(w_dur, c_bit_min, c_bit_max)) begin
                            w_shift_en  = 1'b1;
                            w_shift_bit = 1'b0;
                        end else if (in_window(w_dur, c_one_hi_min, c_one_hi_max)) begin
                            w_shift_en  = 1'b1;
                            w_shift_bit = 1'b1;
                        end else begin
                            w_err        = 1'b1;
                            w_state_next = LEAD_LOW;
                        end
                        if (w_shift_en) begin
                            w_state_next = (r_bit_cnt == 5'd31) ? STOP_LOW : BIT_LOW;
                        end
                    end
                end
                STOP_LOW: begin
                    if (w_rise) begin
                        if (in_window(w_dur, c_bit_min, c_bit_max) && w_frame_ok) begin
                            w_publish = 1'b1;
                        end else begin
                            w_err = 1'b1;
                        end
                        w_state_next = IDLE;
                    end
                end
                RPT_LOW: begin
                    if (w_rise) begin
                        if (in_window(w_dur, c_bit_min, c_bit_max) && r_have_frame) begin
                            w_publish = 1'b1;
                            w_pub_rpt = 1'b1;
                        end else begin
                            w_err = 1'b1;
                        end
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // LSB-first shift register and bit counter
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            if (w_shift_en) begin
                r_shift <= {w_shift_bit, r_shift[31:1]};
            end
            if (w_bit_clr) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    // Remember the last good frame so repeat codes can replay it
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_have_frame <= 1'b0;
            r_last_addr  <= '0;
            r_last_cmd   <= '0;
        end else if (w_publish && !w_pub_rpt) begin
            r_have_frame <= 1'b1;
            r_last_addr  <= w_frame_addr;
            r_last_cmd   <= w_byte2;
        end
    end

    // Output holding register with valid/ready handshake; a publish always wins
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_valid     <= 1'b0;
            out_addr      <= '0;
            out_cmd       <= '0;
            out_repeat    <= 1'b0;
            overrun_pulse <= 1'b0;
        end else if (w_publish) begin
            out_valid     <= 1'b1;
            out_addr      <= w_pub_addr;
            out_cmd       <= w_pub_cmd;
            out_repeat    <= w_pub_rpt;
            overrun_pulse <= out_valid && !out_ready;
        end else begin
            overrun_pulse <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Single-cycle protocol error / timeout indication
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= w_err;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nec_ir_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nec_ir_decoder
//  Description : Directed self-checking bench for nec_ir_decoder at 2 MHz
//                (two clocks per microsecond).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nec_ir_decoder;
    import nec_pkg::*;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        ir_level;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_addr;
    logic [7:0]  out_cmd;
    logic        out_repeat;
    logic        err_pulse;
    logic        overrun_pulse;

    int checks = 0;
    int errors = 0;

    int          hs_cnt  = 0;
    int          err_cnt = 0;
    int          ovr_cnt = 0;
    logic [15:0] hs_addr = '0;
    logic [7:0]  hs_cmd  = '0;
    logic        hs_rep  = 1'b0;

    int exp_err = 0;
    int exp_hs  = 0;

    nec_ir_decoder #(
        .CLK_FREQ_HZ (2_000_000),
        .TIMEOUT_US  (12000)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .ir_level      (ir_level),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_addr      (out_addr),
        .out_cmd       (out_cmd),
        .out_repeat    (out_repeat),
        .err_pulse     (err_pulse),
        .overrun_pulse (overrun_pulse)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Event monitor: handshakes, error pulses and overrun pulses
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (out_valid && out_ready) begin
                hs_cnt  <= hs_cnt + 1;
                hs_addr <= out_addr;
                hs_cmd  <= out_cmd;
                hs_rep  <= out_repeat;
            end
            if (err_pulse)     err_cnt <= err_cnt + 1;
            if (overrun_pulse) ovr_cnt <= ovr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Hold a level so the decoder measures exactly 'us' microseconds
    task automatic hold(input logic lvl, input int us);
        ir_level = lvl;
        repeat (2 * us + 1) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [31:0] word, input int ll, input int lh,
                              input int bl, input int zh, input int oh);
        hold(1'b0, ll);
        hold(1'b1, lh);
        for (int i = 0; i < 32; i++) begin
            hold(1'b0, bl);
            hold(1'b1, word[i] ? oh : zh);
        end
        hold(1'b0, bl);
        hold(1'b1, 100);
    endtask

    task automatic send_repeat();
        hold(1'b0, 9000);
        hold(1'b1, 2250);
        hold(1'b0, 560);
        hold(1'b1, 100);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        ir_level  = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(negedge sys_clk);

        // Reset state
        check("rst_valid",   32'(out_valid), 32'd0);
        check("rst_addr",    32'(out_addr), 32'd0);
        check("rst_cmd",     32'(out_cmd), 32'd0);
        check("rst_repeat",  32'(out_repeat), 32'd0);
        check("rst_err",     32'(err_pulse), 32'd0);
        check("rst_overrun", 32'(overrun_pulse), 32'd0);
        sys_rst_n = 1'b1;
        hold(1'b1, 100);

        // Repeat code with no stored frame
        send_repeat();
        exp_err++;
        check("rpt_noframe_err", 32'(err_cnt), 32'(exp_err));
        check("rpt_noframe_valid", 32'(out_valid), 32'd0);

        // Leader just outside the low window on both sides
        hold(1'b0, 7999);
        hold(1'b1, 100);
        exp_err++;
        check("lead_7999_err", 32'(err_cnt), 32'(exp_err));
        hold(1'b0, 10001);
        hold(1'b1, 100);
        exp_err++;
        check("lead_10001_err", 32'(err_cnt), 32'(exp_err));

        // Nominal frame 00 FF 45 BA
        send_frame(32'hBA45FF00, 9000, 4500, 560, 560, 1690);
        exp_hs++;
        check("f1_hs", 32'(hs_cnt), 32'(exp_hs));
        check("f1_addr", 32'(hs_addr), 32'h0000);
        check("f1_cmd", 32'(hs_cmd), 32'h45);
        check("f1_rep", 32'(hs_rep), 32'd0);
        check("f1_err", 32'(err_cnt), 32'(exp_err));

        // Repeat code 40 ms later replays the last frame
        hold(1'b1, 40000);
        send_repeat();
        exp_hs++;
        check("rpt_hs", 32'(hs_cnt), 32'(exp_hs));
        check("rpt_cmd", 32'(hs_cmd), 32'h45);
        check("rpt_addr", 32'(hs_addr), 32'h0000);
        check("rpt_rep", 32'(hs_rep), 32'd1);

        // Bad command inverse 00 FF 45 BB
        send_frame(32'hBB45FF00, 9000, 4500, 560, 560, 1690);
        exp_err++;
        check("badcmd_err", 32'(err_cnt), 32'(exp_err));
        check("badcmd_hs", 32'(hs_cnt), 32'(exp_hs));

        // Short leader, then a frame 00 FF 18 E7 at the upper window limits
        hold(1'b0, 5000);
        hold(1'b1, 1000);
        exp_err++;
        check("shortlead_err", 32'(err_cnt), 32'(exp_err));
        send_frame(32'hE718FF00, 10000, 5000, 700, 700, 1900);
        exp_hs++;
        check("maxwin_hs", 32'(hs_cnt), 32'(exp_hs));
        check("maxwin_cmd", 32'(hs_cmd), 32'h18);
        check("maxwin_rep", 32'(hs_rep), 32'd0);
        check("maxwin_err", 32'(err_cnt), 32'(exp_err));

        // Stall after 16 bits: timeout fires 12000 us after the last edge
        hold(1'b0, 9000);
        hold(1'b1, 4500);
        for (int i = 0; i < 16; i++) begin
            hold(1'b0, 560);
            hold(1'b1, (i >= 8) ? 1690 : 560);
        end
        hold(1'b0, 560);
        ir_level = 1'b1;
        repeat (2 * 11990) @(negedge sys_clk);
        check("stall_early_err", 32'(err_cnt), 32'(exp_err));
        repeat (40) @(negedge sys_clk);
        exp_err++;
        check("stall_timeout_err", 32'(err_cnt), 32'(exp_err));
        check("stall_state_idle", 32'(dut.r_state), 32'(IDLE));
        check("stall_hs", 32'(hs_cnt), 32'(exp_hs));
        hold(1'b1, 1000);

        // Overrun: two frames without a consumer, second at the lower limits
        out_ready = 1'b0;
        send_frame(32'hBA45FF00, 9000, 4500, 560, 560, 1690);
        check("ovr_first_valid", 32'(out_valid), 32'd1);
        check("ovr_first_cmd", 32'(out_cmd), 32'h45);
        check("ovr_first_cnt", 32'(ovr_cnt), 32'd0);
        send_frame(32'hB946FF00, 8000, 4000, 400, 400, 1400);
        check("ovr_second_cnt", 32'(ovr_cnt), 32'd1);
        check("ovr_second_valid", 32'(out_valid), 32'd1);
        check("ovr_second_cmd", 32'(out_cmd), 32'h46);
        check("ovr_second_rep", 32'(out_repeat), 32'd0);
        check("ovr_no_hs", 32'(hs_cnt), 32'(exp_hs));
        out_ready = 1'b1;
        repeat (4) @(negedge sys_clk);
        exp_hs++;
        check("ovr_drain_hs", 32'(hs_cnt), 32'(exp_hs));
        check("ovr_drain_cmd", 32'(hs_cmd), 32'h46);
        check("ovr_drain_valid", 32'(out_valid), 32'd0);

        // Frame 12 34 45 BA: valid only with the extended address build
        send_frame(32'hBA453412, 9000, 4500, 560, 560, 1690);
`ifdef NEC_EXT_ADDR_EN
        exp_hs++;
        check("ext_hs", 32'(hs_cnt), 32'(exp_hs));
        check("ext_addr", 32'(hs_addr), 32'h3412);
        check("ext_cmd", 32'(hs_cmd), 32'h45);
        check("ext_err", 32'(err_cnt), 32'(exp_err));
`else
        exp_err++;
        check("std_badaddr_err", 32'(err_cnt), 32'(exp_err));
        check("std_badaddr_hs", 32'(hs_cnt), 32'(exp_hs));
`endif

        // Reset in the middle of a frame discards everything incl. stored frame
        hold(1'b0, 9000);
        hold(1'b1, 4500);
        for (int i = 0; i < 4; i++) begin
            hold(1'b0, 560);
            hold(1'b1, 1690);
        end
        ir_level = 1'b0;
        repeat (100) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        ir_level  = 1'b1;
        repeat (4) @(negedge sys_clk);
        check("midrst_state", 32'(dut.r_state), 32'(IDLE));
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_cmd", 32'(out_cmd), 32'd0);
        sys_rst_n = 1'b1;
        hold(1'b1, 100);
        send_repeat();
        exp_err++;
        check("midrst_rpt_err", 32'(err_cnt), 32'(exp_err));
        check("midrst_rpt_hs", 32'(hs_cnt), 32'(exp_hs));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
